// File: rtl/activation_serializer.sv
// Captures a vector of signed activations and emits it as masked, Lanes-wide
// write beats to consecutive buffer addresses under a valid/ready handshake.
module activation_serializer #(
   parameter int unsigned N           = 16,
   parameter int unsigned EngineCount = 64,
   parameter int unsigned Lanes       = 4,
   parameter int unsigned AddrWidth   = 10
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [11:0]            count_i,
   input  logic [AddrWidth-1:0]   base_addr_i,
   input  logic signed [N-1:0]    value_i [EngineCount],
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   wr_valid_o,
   input  logic                   wr_ready_i,
   output logic [AddrWidth-1:0]   wr_addr_o,
   output logic [N*Lanes-1:0]     wr_data_o,
   output logic [Lanes-1:0]       wr_mask_o
);

   localparam int unsigned CntW = 12;
   localparam int unsigned IdxW = CntW + 1;
   localparam int unsigned SelW = (EngineCount > 1) ? $clog2(EngineCount) : 1;

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic signed [N-1:0]   r_values [EngineCount];
   logic [CntW-1:0]       r_count;
   logic [IdxW-1:0]       r_idx;

   logic [CntW-1:0]       w_count_clamp;
   logic [CntW-1:0]       w_count_eff;
   logic [IdxW-1:0]       w_idx_next;
   logic [IdxW-1:0]       w_elem;
   logic                  w_capture;
   logic                  w_advance;
   logic                  w_last;
   logic [N*Lanes-1:0]    w_data;
   logic [Lanes-1:0]      w_mask;

   // Handshake qualifiers and index of the first element of the next beat
   always_comb begin
      w_count_clamp = (count_i > CntW'(EngineCount)) ? CntW'(EngineCount) : count_i;
      w_capture     = (r_state == IDLE) && start_i;
      w_advance     = (r_state == SEND) && wr_valid_o && wr_ready_i;
      w_last        = w_advance && ((r_idx + IdxW'(Lanes)) >= IdxW'(r_count));
      w_count_eff   = w_capture ? w_count_clamp : r_count;
      w_idx_next    = w_capture ? '0 : r_idx + IdxW'(Lanes);
   end

   // Beat 0 is built straight from value_i so it can be registered on the capture edge
   always_comb begin
      w_data = '0;
      w_mask = '0;
      w_elem = '0;
      for (int k = 0; k < Lanes; k++) begin
         w_elem = w_idx_next + IdxW'(k);
         if (w_elem < IdxW'(w_count_eff)) begin
            w_mask[k]        = 1'b1;
            w_data[k*N +: N] = w_capture ? value_i[SelW'(w_elem)] : r_values[SelW'(w_elem)];
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_capture) w_state_next = (w_count_clamp == '0) ? DONE : SEND;
         SEND:    if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_idx      <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         wr_valid_o <= 1'b0;
         wr_addr_o  <= '0;
         wr_data_o  <= '0;
         wr_mask_o  <= '0;
         for (int i = 0; i < EngineCount; i++) r_values[i] <= '0;
      end else begin
         r_state <= w_state_next;
         busy_o  <= (w_state_next != IDLE);
         done_o  <= (w_state_next == DONE);
         if (w_capture) begin
            r_values   <= value_i;
            r_count    <= w_count_clamp;
            r_idx      <= '0;
            wr_addr_o  <= base_addr_i;
            wr_valid_o <= (w_count_clamp != '0);
            wr_data_o  <= w_data;
            wr_mask_o  <= w_mask;
         end else if (w_last) begin
            wr_valid_o <= 1'b0;
            wr_data_o  <= '0;
            wr_mask_o  <= '0;
         end else if (w_advance) begin
            r_idx     <= w_idx_next;
            wr_addr_o <= wr_addr_o + AddrWidth'(1);
            wr_data_o <= w_data;
            wr_mask_o <= w_mask;
         end
      end
   end

endmodule

// File: tb/tb_activation_serializer.sv
// Self-checking bench for activation_serializer: directed and randomized jobs
// compared against a beat list computed from the captured vector.
module tb_activation_serializer;

   localparam int unsigned N  = 16;
   localparam int unsigned EC = 8;
   localparam int unsigned LN = 4;
   localparam int unsigned AW = 10;

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 start_i;
   logic [11:0]          count_i;
   logic [AW-1:0]        base_addr_i;
   logic signed [N-1:0]  value_i [EC];
   logic                 busy_o;
   logic                 done_o;
   logic                 wr_valid_o;
   logic                 wr_ready_i;
   logic [AW-1:0]        wr_addr_o;
   logic [N*LN-1:0]      wr_data_o;
   logic [LN-1:0]        wr_mask_o;

   int checks = 0;
   int errs   = 0;

   activation_serializer #(.N(N), .EngineCount(EC), .Lanes(LN), .AddrWidth(AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .count_i(count_i),
      .base_addr_i(base_addr_i), .value_i(value_i), .busy_o(busy_o), .done_o(done_o),
      .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o), .wr_mask_o(wr_mask_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_valid"}, 64'(wr_valid_o), 64'd0);
      chk({tag, "_done"},  64'(done_o), 64'd0);
      chk({tag, "_busy"},  64'(busy_o), 64'd0);
   endtask

   // rmode: 0 ready always high, 1 random ready, 2 ready low for 3 cycles on beat 0
   task automatic run_job(input int cnt, input int base, input int rmode, input bit seq);
      logic [N-1:0]  cap [EC];
      logic [63:0]   exp_data;
      logic [LN-1:0] exp_mask;
      int eff, nb, b, guard, lo, e;
      bit rdy, acc;
      for (int i = 0; i < EC; i++) begin
         cap[i]     = seq ? N'(i + 1) : N'($urandom);
         value_i[i] = cap[i];
      end
      start_i     = 1'b1;
      count_i     = 12'(cnt);
      base_addr_i = AW'(base);
      wr_ready_i  = 1'b1;
      eff = (cnt > EC) ? EC : cnt;
      nb  = (eff + LN - 1) / LN;
      step();
      start_i = 1'b0;
      b = 0; guard = 0; lo = 0;
      while (b < nb && guard < 100) begin
         exp_data = '0;
         exp_mask = '0;
         for (int k = 0; k < LN; k++) begin
            e = b * LN + k;
            if (e < eff) begin
               exp_data[k*N +: N] = cap[e];
               exp_mask[k]        = 1'b1;
            end
         end
         chk("beat_valid", 64'(wr_valid_o), 64'd1);
         chk("beat_busy",  64'(busy_o), 64'd1);
         chk("beat_done",  64'(done_o), 64'd0);
         chk("beat_addr",  64'(wr_addr_o), 64'((base + b) % (1 << AW)));
         chk("beat_data",  64'(wr_data_o), exp_data);
         chk("beat_mask",  64'(wr_mask_o), 64'(exp_mask));
         if (rmode == 0) rdy = 1'b1;
         else if (rmode == 1) rdy = 1'($urandom);
         else if (b == 0 && lo < 3) begin rdy = 1'b0; lo++; end
         else rdy = 1'b1;
         wr_ready_i = rdy;
         if (rmode != 0) begin
            for (int i = 0; i < EC; i++) value_i[i] = N'($urandom);
            start_i = 1'($urandom);
            count_i = 12'($urandom_range(0, 12));
         end
         acc = wr_valid_o && rdy;
         step();
         if (acc) b++;
         guard++;
      end
      chk("job_timeout", 64'(guard >= 100), 64'd0);
      chk("done_pulse", 64'(done_o), 64'd1);
      chk("done_busy",  64'(busy_o), 64'd1);
      chk("done_valid", 64'(wr_valid_o), 64'd0);
      start_i    = 1'($urandom);
      wr_ready_i = 1'($urandom);
      step();
      start_i = 1'b0;
      chk_quiet("after_done");
   endtask

   initial begin
      rst_i       = 1'b1;
      start_i     = 1'b0;
      count_i     = '0;
      base_addr_i = '0;
      wr_ready_i  = 1'b1;
      for (int i = 0; i < EC; i++) value_i[i] = '0;
      step();
      step();
      chk_quiet("reset");
      chk("reset_addr", 64'(wr_addr_o), 64'd0);
      chk("reset_data", 64'(wr_data_o), 64'd0);
      chk("reset_mask", 64'(wr_mask_o), 64'd0);
      rst_i = 1'b0;
      step();
      chk_quiet("idle");

      run_job(8, 5, 0, 1'b1);
      run_job(6, 5, 0, 1'b1);
      run_job(20, 5, 0, 1'b1);
      run_job(8, 1023, 0, 1'b0);
      run_job(8, 100, 2, 1'b0);
      run_job(0, 7, 0, 1'b0);
      run_job(0, 7, 1, 1'b0);
      for (int j = 0; j < 25; j++)
         run_job($urandom_range(0, 12), $urandom_range(0, 1023), $urandom_range(0, 2), 1'b0);

      // Reset while beat 1 is pending: outputs drop at once, job is abandoned
      start_i     = 1'b1;
      count_i     = 12'd8;
      base_addr_i = '0;
      wr_ready_i  = 1'b1;
      for (int i = 0; i < EC; i++) value_i[i] = N'($urandom);
      step();
      start_i = 1'b0;
      step();
      chk("pre_rst_valid", 64'(wr_valid_o), 64'd1);
      rst_i = 1'b1;
      #1;
      chk_quiet("rst_async");
      chk("rst_addr", 64'(wr_addr_o), 64'd0);
      chk("rst_data", 64'(wr_data_o), 64'd0);
      chk("rst_mask", 64'(wr_mask_o), 64'd0);
      step();
      rst_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         chk_quiet("post_rst");
      end
      run_job(5, 3, 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
